// File: rtl/aes_round_sequencer_if.sv
// Block-stream and key-lookup bundle between the AES sequencer (slave) and its
// front end / key store (master).
interface aes_round_sequencer_if #(
    parameter int RKW = 4
);
    logic           abort;
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   in_data;
    logic           in_encrypt;
    logic [RKW-1:0] rk_idx;
    logic [127:0]   rk_data;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_data;
    logic           busy;

    modport slave (
        input  abort, in_valid, in_data, in_encrypt, rk_data, out_ready,
        output in_ready, rk_idx, out_valid, out_data, busy
    );

    modport master (
        output abort, in_valid, in_data, in_encrypt, rk_data, out_ready,
        input  in_ready, rk_idx, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128/192/256 round engine, encrypt or decrypt, one round key per cycle; NR cycles accept-to-result.
// Accepts only in IDLE; DONE holds out_data/out_valid until out_ready, abort flushes to IDLE from any state.
module aes_round_sequencer #(
    parameter int NR  = 10,
    parameter int RKW = 4
) (
    input logic                  HCLK,
    input logic                  n_rst,
    aes_round_sequencer_if.slave bus
);
    if (!(NR == 10 || NR == 12 || NR == 14) || (2 ** RKW) <= NR) begin : g_bad_param
        $error("aes_round_sequencer: NR must be 10, 12 or 14 and 2**RKW must exceed NR");
    end

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;
    localparam logic [RKW-1:0] NR_K = RKW'(NR);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as a^254 = product of a^(2^k) for k=1..7; zero maps to zero as the S-box needs.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic enc, input logic [7:0] a);
        logic [7:0] b;
        logic [7:0] y;
        if (enc) begin
            b = ginv(a);
            y = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end else begin
            b = rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
            y = ginv(b);
        end
        return y;
    endfunction

    function automatic logic [7:0] mix_coef(input logic enc, input int j);
        logic [7:0] c;
        case (j)
            0:       c = enc ? 8'h02 : 8'h0e;
            1:       c = enc ? 8'h03 : 8'h0b;
            2:       c = enc ? 8'h01 : 8'h0d;
            default: c = enc ? 8'h01 : 8'h09;
        endcase
        return c;
    endfunction

    // Byte n = column n/4, row n%4, MSB first. Decrypt keys arrive pre-mixed, so round = InvSub, InvShift, InvMix, AddKey.
    function automatic logic [127:0] aes_round(input logic enc, input logic last,
                                               input logic [127:0] s, input logic [127:0] k);
        logic [127:0] b;
        logic [127:0] t;
        logic [127:0] o;
        logic [7:0]   m;
        int           src;
        for (int i = 0; i < 16; i++) b[127-8*i -: 8] = sbox(enc, s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = 4 * ((enc ? c + r : c - r + 4) % 4) + r;
                t[127-8*(4*c+r) -: 8] = b[127-8*src -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                m = 8'h00;
                for (int j = 0; j < 4; j++) m = m ^ gmul(mix_coef(enc, (j - r + 4) % 4), t[127-8*(4*c+j) -: 8]);
                o[127-8*(4*c+r) -: 8] = last ? t[127-8*(4*c+r) -: 8] : m;
            end
        end
        return o ^ k;
    endfunction

    state_e         state_q, state_d;
    logic [127:0]   st_q, st_d, out_data_q, out_data_d, round_out;
    logic [RKW-1:0] r_q, r_d, rk_idx_c;
    logic           mode_q, mode_d;
    logic           in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;

    always_comb begin
        rk_idx_c = '0;
        case (state_q)
            IDLE:    rk_idx_c = bus.in_encrypt ? '0 : NR_K;
            ROUND:   rk_idx_c = mode_q ? r_q : NR_K - r_q;
            FINAL:   rk_idx_c = mode_q ? NR_K : '0;
            default: rk_idx_c = '0;
        endcase
    end

    always_comb begin
        round_out = aes_round(mode_q, state_q == FINAL, st_q, bus.rk_data);
        state_d   = state_q;
        st_d      = st_q;
        r_d       = r_q;
        mode_d    = mode_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    st_d    = bus.in_data ^ bus.rk_data;
                    mode_d  = bus.in_encrypt;
                    r_d     = RKW'(1);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                st_d = round_out;
                if (r_q == NR_K - RKW'(1)) state_d = FINAL;
                else                       r_d     = r_q + RKW'(1);
            end
            FINAL: begin
                st_d    = round_out;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.abort) begin
            state_d = IDLE;
            st_d    = '0;
            r_d     = '0;
            mode_d  = 1'b0;
        end
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        out_data_d  = (state_d == DONE) ? st_d : '0;
    end

    always_ff @(posedge HCLK or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            st_q        <= '0;
            r_q         <= '0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            r_q         <= r_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out_data  = out_data_q;
    assign bus.rk_idx    = rk_idx_c;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: NR=10/12/14 instances fed from an expanded-key store, FIPS-197 vectors.
module tb_aes_round_sequencer;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT12 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT14 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    typedef struct {
        int           inst;
        bit           enc;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    logic         HCLK  = 1'b0;
    logic         n_rst = 1'b0;
    logic [2:0]   in_valid, in_encrypt, out_ready, abort;
    logic [127:0] in_data [3];
    logic [127:0] ks [3][16];
    wire  [2:0]   in_ready, out_valid, busy;
    wire  [127:0] out_data [3];
    wire  [3:0]   rk_idx [3];
    int           n_chk  = 0;
    int           n_pass = 0;

    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_round_sequencer_if #(.RKW(4)) bus ();
        assign bus.abort      = abort[g];
        assign bus.in_valid   = in_valid[g];
        assign bus.in_data    = in_data[g];
        assign bus.in_encrypt = in_encrypt[g];
        assign bus.out_ready  = out_ready[g];
        assign bus.rk_data    = ks[g][bus.rk_idx];
        assign in_ready[g]    = bus.in_ready;
        assign out_valid[g]   = bus.out_valid;
        assign out_data[g]    = bus.out_data;
        assign busy[g]        = bus.busy;
        assign rk_idx[g]      = bus.rk_idx;
        aes_round_sequencer #(.NR(10 + 2 * g), .RKW(4)) dut (
            .HCLK  (HCLK),
            .n_rst (n_rst),
            .bus   (bus.slave)
        );
    end

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09),
                                 gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d),
                                 gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b),
                                 gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e)};
        end
        return o;
    endfunction

    // Key store for instance g: FIPS key expansion, inverse-cipher form (middle keys InvMixColumns'd) when dec.
    task automatic load_keys(input int g, input bit dec);
        logic [31:0]  w [60];
        logic [31:0]  t;
        logic [7:0]   rcon;
        logic [255:0] key;
        int           nk, nr;
        key  = KEY;
        nk   = 4 + 2 * g;
        nr   = 10 + 2 * g;
        rcon = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                    rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int i = 0; i <= nr; i++) begin
            ks[g][i] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
            if (dec && i > 0 && i < nr) ks[g][i] = inv_mix(ks[g][i]);
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Called at the first negedge after the accept edge; lat counts edges after accept until out_valid.
    task automatic wait_done(input int g, input bit enc, output int lat, output bit seq_ok);
        int nr;
        nr     = 10 + 2 * g;
        lat    = 0;
        seq_ok = 1'b1;
        while (out_valid[g] !== 1'b1 && lat < 40) begin
            if (rk_idx[g] !== 4'(enc ? lat + 1 : nr - 1 - lat)) seq_ok = 1'b0;
            @(posedge HCLK);
            @(negedge HCLK);
            lat++;
        end
    endtask

    task automatic run_block(input int g, input bit enc, input logic [127:0] din,
                             input logic [127:0] exp, input string name);
        int lat;
        bit seq_ok;
        int nr;
        nr = 10 + 2 * g;
        @(negedge HCLK);
        in_valid[g]   = 1'b1;
        in_encrypt[g] = enc;
        in_data[g]    = din;
        out_ready[g]  = 1'b1;
        #1;
        check({name, "_idle_rk_idx"}, 128'(rk_idx[g]), enc ? 128'd0 : 128'(nr));
        @(posedge HCLK);
        @(negedge HCLK);
        in_valid[g]   = 1'b0;
        in_data[g]    = ~din;
        in_encrypt[g] = ~enc;
        wait_done(g, enc, lat, seq_ok);
        check({name, "_latency"}, 128'(lat), 128'(nr));
        check({name, "_rk_seq"}, 128'(seq_ok), 128'd1);
        check({name, "_out_data"}, out_data[g], exp);
        @(posedge HCLK);
        @(negedge HCLK);
        in_encrypt[g] = 1'b1;
        check({name, "_release_flags"}, 128'({out_valid[g], busy[g], in_ready[g]}), 128'(3'b001));
        check({name, "_release_data"}, out_data[g], 128'd0);
    endtask

    initial begin
        vec_t vecs [4];
        int   lat;
        bit   seq_ok, held_ok, seen;
        vecs[0] = '{0, 1'b1, PT, CT10};
        vecs[1] = '{0, 1'b0, CT10, PT};
        vecs[2] = '{1, 1'b1, PT, CT12};
        vecs[3] = '{2, 1'b1, PT, CT14};
        in_valid   = '0;
        in_encrypt = '1;
        out_ready  = '0;
        abort      = '0;
        for (int g = 0; g < 3; g++) in_data[g] = '0;
        for (int g = 0; g < 3; g++) load_keys(g, 1'b0);

        #12;
        check("rst_in_ready", 128'(in_ready[0]), 128'd1);
        check("rst_out_valid", 128'(out_valid[0]), 128'd0);
        check("rst_out_data", out_data[0], 128'd0);
        check("rst_busy", 128'(busy[0]), 128'd0);
        check("rst_rk_idx", 128'(rk_idx[0]), 128'd0);
        @(negedge HCLK);
        n_rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            load_keys(vecs[i].inst, !vecs[i].enc);
            run_block(vecs[i].inst, vecs[i].enc, vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));
        end
        load_keys(0, 1'b0);

        // Backpressure with a second block waiting throughout.
        @(negedge HCLK);
        in_valid[0] = 1'b1;
        in_data[0]  = PT;
        out_ready[0] = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK);
        wait_done(0, 1'b1, lat, seq_ok);
        check("bp_first_result", out_data[0], CT10);
        held_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge HCLK);
            @(negedge HCLK);
            if (out_valid[0] !== 1'b1 || out_data[0] !== CT10 || in_ready[0] !== 1'b0) held_ok = 1'b0;
        end
        check("bp_stall_stable", 128'(held_ok), 128'd1);
        out_ready[0] = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        check("bp_after_handshake", 128'({out_valid[0], busy[0], in_ready[0]}), 128'(3'b001));
        @(posedge HCLK);
        @(negedge HCLK);
        check("bp_second_accept", 128'({busy[0], in_ready[0]}), 128'(2'b10));
        in_valid[0] = 1'b0;
        wait_done(0, 1'b1, lat, seq_ok);
        check("bp_second_latency", 128'(lat), 128'd10);
        check("bp_second_result", out_data[0], CT10);
        @(posedge HCLK);
        @(negedge HCLK);

        // Abort while in ROUND with r=5.
        in_valid[0] = 1'b1;
        in_data[0]  = PT;
        @(posedge HCLK);
        @(negedge HCLK);
        in_valid[0] = 1'b0;
        repeat (4) begin
            @(posedge HCLK);
            @(negedge HCLK);
        end
        check("abort_rk_idx_r5", 128'(rk_idx[0]), 128'd5);
        abort[0] = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        abort[0] = 1'b0;
        check("abort_idle", 128'({out_valid[0], busy[0], in_ready[0]}), 128'(3'b001));
        seen = 1'b0;
        repeat (15) begin
            @(posedge HCLK);
            @(negedge HCLK);
            if (out_valid[0] !== 1'b0) seen = 1'b1;
        end
        check("abort_no_output", 128'(seen), 128'd0);
        run_block(0, 1'b1, PT, CT10, "post_abort");

        // Abort in IDLE blocks the accept.
        @(negedge HCLK);
        in_valid[0] = 1'b1;
        abort[0]    = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        in_valid[0] = 1'b0;
        abort[0]    = 1'b0;
        check("abort_idle_no_accept", 128'({busy[0], in_ready[0]}), 128'(2'b01));

        // Asynchronous reset between edges while in FINAL.
        @(negedge HCLK);
        in_valid[0] = 1'b1;
        in_data[0]  = PT;
        @(posedge HCLK);
        @(negedge HCLK);
        in_valid[0] = 1'b0;
        repeat (9) begin
            @(posedge HCLK);
            @(negedge HCLK);
        end
        check("final_rk_idx", 128'(rk_idx[0]), 128'd10);
        #2 n_rst = 1'b0;
        #1;
        check("async_rst_flags", 128'({out_valid[0], busy[0], in_ready[0]}), 128'(3'b001));
        check("async_rst_out_data", out_data[0], 128'd0);
        @(negedge HCLK);
        n_rst = 1'b1;
        run_block(0, 1'b1, PT, CT10, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Parametrised, handshaked AES round engine that replaces the fixed 10-round, encrypt-only iterator. It supports AES-128/192/256 round counts and both encrypt and decrypt directions. It runs one 128-bit block at a time through the existing `generalRound` and `lastRound` datapaths, fetching one round key per cycle from an external key store. It sits between the AHB slave front end (`in_*`/`out_*` streams) and the key-expansion block (`rk_*` lookup).

## Interface

- `NR`, 10, number of rounds; legal values 10, 12 and 14; any other value is a compile-time error.
- `RKW`, 4, width of the round-key index; must satisfy 2^RKW > NR.

- `HCLK`  in  1  clock, all state on rising edge.
- `n_rst`  in  1  reset; asynchronous, active-low.
- `abort`  in  1  synchronous flush; highest priority after reset.
- `in_valid`  in  1  input block valid.
- `in_ready`  out  1  engine can accept a block.
- `in_data`  in  128  plaintext or ciphertext.
- `in_encrypt`  in  1  mode: 1 = encrypt, 0 = decrypt; sampled on accept.
- `rk_idx`  out  RKW  round-key index requested this cycle.
- `rk_data`  in  128  round key for `rk_idx`; combinational, same cycle.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_data`  out  128  result block.
- `busy`  out  1  high in ROUND, FINAL and DONE.

## Operation

- **States**
  - IDLE, ROUND, FINAL, DONE.
  - Registers: 128-bit `st`, round counter `r` (RKW bits), latched `mode`.
- **IDLE**
  - `in_ready` = 1.
  - `rk_idx` = `in_encrypt` ? 0 : NR.
  - On `in_valid && in_ready`: `st` <= `in_data ^ rk_data`, `mode` <= `in_encrypt`, `r` <= 1, go to ROUND.
- **ROUND**
  - `rk_idx` = `mode` ? `r` : NR−`r`.
  - `st` <= `generalRound(mode, st, rk_data)`.
  - If `r` == NR−1, go to FINAL; else `r` <= `r`+1.
- **FINAL**
  - `rk_idx` = `mode` ? NR : 0.
  - `st` <= `lastRound(mode, st, rk_data)`.
  - Go to DONE.
- **DONE**
  - `out_valid` = 1; `out_data` = `st`, held stable while `out_valid` is high.
  - On `out_ready`: go to IDLE.
  - `rk_idx` = 0.
- **Key ordering.** Decrypt walks keys NR down to 0. The key store supplies inverse-cipher-form keys for decrypt; the sequencer only orders them.
- **`out_data` outside DONE** is 0, not `st`, so intermediate state never leaks.
- **`in_ready`** is 0 outside IDLE. The engine never accepts a new block in the DONE handshake cycle.
- **`in_encrypt` and `in_data`** are ignored except on the accept edge.
- **`abort`** in any state, at the next edge: `st`, `r` and `mode` go to 0, state goes to IDLE, and no output is produced. Abort in IDLE with `in_valid` high: the block is not accepted.
- **Reset mid-operation:** immediate return to IDLE with all registers cleared; the block is lost.

## Timing

- Reset values:
  - `in_ready` = 1
  - `out_valid` = 0
  - `out_data` = 0
  - `busy` = 0
  - `rk_idx` = 0 (`in_encrypt` = 1 path irrelevant: IDLE drives per `in_encrypt`)
  - internal `st`, `r`, `mode` = 0
- Accept at edge E0.
  - ROUND occupies NR−1 cycles.
  - FINAL occupies 1 cycle.
  - `out_valid` rises after edge E0+NR (NR+1 edges after the accept cycle begins).
- Latency from accept edge to `out_valid` high: NR cycles. Minimum period per block with `out_ready` held high: NR+2 cycles (10: 12, 12: 14, 14: 16).
- `rk_idx` is a function of registered state only, plus `in_encrypt` in IDLE. `rk_data` must settle within the same cycle; there is no key-fetch wait state.
- `out_ready` low stalls indefinitely in DONE with `out_data` and `out_valid` unchanged.
- `abort` and `out_ready` in the same DONE cycle: abort wins, and the transfer is counted as not taken by the consumer contract (consumer must qualify with `!abort`).

## Test plan

- **AES-128 encrypt, NR=10.**
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, PT 00112233445566778899aabbccddeeff.
  - Required: `out_data` = 69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` exactly 10 cycles after accept, `rk_idx` sequence 0,1,…,10.
- **AES-128 decrypt, NR=10.**
  - Stimulus: CT 69c4e0d86a7b0430d8cdb78070b4c55a, same key.
  - Required: 00112233445566778899aabbccddeeff, `rk_idx` sequence 10,9,…,0.
- **NR=12 and NR=14 builds.**
  - Keys 000102…17 and 000102…1f, FIPS PT as above.
  - Required: dda97ca4864cdfe06eaf70a0ec0d7191 (latency 12) and 8ea2b7ca516745bfeafc49904b496089 (latency 14).
- **Backpressure.**
  - Stimulus: hold `out_ready`=0 for 20 cycles after `out_valid`; drive `in_valid`=1 with a new block throughout.
  - Required: `out_data` stable, `in_ready`=0, no second accept; second block is accepted the cycle after the handshake.
- **Abort in ROUND.**
  - Stimulus: assert `abort` when `r`=5.
  - Required: next cycle IDLE, `in_ready`=1, `busy`=0, `out_valid` never asserted; the following block encrypts correctly.
- **Async reset mid-operation.**
  - Stimulus: drop `n_rst` between edges while in FINAL.
  - Required: `out_valid`=0, `out_data`=0, `in_ready`=1 immediately, without waiting for `HCLK`.
